// File: rtl/clk_div_pkg.sv
// Shared defaults and ratio type for the clk_div block.
// Odd-ratio support is selected by the CLK_DIV_ODD_EN macro (see clk_div_cnt).
package clk_div_pkg;

  localparam int unsigned MAX_RATIO_DEF = 10;
  localparam int unsigned RATIO_BIT_DEF = $clog2(MAX_RATIO_DEF) + 1;

  typedef logic [RATIO_BIT_DEF-1:0] ratio_t;

endpackage

// File: rtl/clk_div_cnt.sv
// Phase counter, comparator and phase-length selection for clk_div.
// CLK_DIV_ODD_EN: when defined, odd ratios divide exactly; otherwise the ratio LSB is dropped.
module clk_div_cnt
  import clk_div_pkg::*;
#(
  parameter int unsigned MAX_RATIO = MAX_RATIO_DEF,
  parameter int unsigned RATIO_BIT = $clog2(MAX_RATIO) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [RATIO_BIT-1:0] ratio_i,
  input  logic                 phase_hi_i,
  output logic                 active_o,
  output logic                 toggle_o
);

  logic [RATIO_BIT-1:0] n_sat;
  logic [RATIO_BIT-1:0] n_eff;
  logic [RATIO_BIT-1:0] plen;
  logic [RATIO_BIT-1:0] cnt_q;
  logic [RATIO_BIT-1:0] cnt_d;

  always_comb begin
    n_sat = (ratio_i > RATIO_BIT'(MAX_RATIO)) ? RATIO_BIT'(MAX_RATIO) : ratio_i;
`ifdef CLK_DIV_ODD_EN
    n_eff = n_sat;
`else
    n_eff = n_sat & ~RATIO_BIT'(1);
`endif
    active_o = en_i && (ratio_i >= RATIO_BIT'(2));
    // Low phase takes the ceiling half, high phase the floor half.
    plen     = phase_hi_i ? (n_eff >> 1) : ((n_eff >> 1) + RATIO_BIT'(n_eff[0]));
    toggle_o = active_o && (cnt_q >= (plen - RATIO_BIT'(1)));
    cnt_d    = cnt_q + RATIO_BIT'(1);
    if (!active_o || toggle_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clk_div.sv
// Integer clock divider with combinational bypass for ratios 0/1 or when disabled.
// Odd-ratio support is selected by the CLK_DIV_ODD_EN macro.
module clk_div
  import clk_div_pkg::*;
#(
  parameter int unsigned MAX_RATIO = MAX_RATIO_DEF,
  parameter int unsigned RATIO_BIT = $clog2(MAX_RATIO) + 1
) (
  input  logic                 i_ref_clk,
  input  logic                 i_rst,
  input  logic                 i_clk_en,
  input  logic [RATIO_BIT-1:0] i_div_ratio,
  output logic                 o_div_clk
);

  logic div_q;
  logic div_d;
  logic active;
  logic toggle;

  clk_div_cnt #(
    .MAX_RATIO (MAX_RATIO),
    .RATIO_BIT (RATIO_BIT)
  ) u_cnt (
    .clk_i      (i_ref_clk),
    .rst_i      (i_rst),
    .en_i       (i_clk_en),
    .ratio_i    (i_div_ratio),
    .phase_hi_i (div_q),
    .active_o   (active),
    .toggle_o   (toggle)
  );

  always_comb begin
    div_d = div_q;
    if (!active) begin
      div_d = 1'b0;
    end else if (toggle) begin
      div_d = ~div_q;
    end
  end

  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      div_q <= 1'b0;
    end else begin
      div_q <= div_d;
    end
  end

  // Mux select deliberately ignores reset so bypass stays live while in reset.
  always_comb begin
    o_div_clk = active ? div_q : i_ref_clk;
  end

endmodule

// File: tb/tb_clk_div.sv
// Self-checking bench for clk_div: directed scenarios plus randomized segments
// checked against a cycle-count model of the divided waveform.
module tb_clk_div;
  import clk_div_pkg::*;

  logic   clk;
  logic   rst;
  logic   en;
  ratio_t ratio;
  logic   o_div_clk;

  int unsigned n_assert;
  int unsigned n_fail;

  // reference model state
  logic        m_act;
  logic        mq;
  int unsigned mt;

  // waveform measurement
  logic        prev_o;
  logic        last_pos_o;
  longint      last_rise;
  longint      prev_rise;
  longint      hi_len;

  clk_div #(
    .MAX_RATIO (10),
    .RATIO_BIT (5)
  ) dut (
    .i_ref_clk   (clk),
    .i_rst       (rst),
    .i_clk_en    (en),
    .i_div_ratio (ratio),
    .o_div_clk   (o_div_clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned neff(input int unsigned r);
    int unsigned n;
    n = (r > 10) ? 10 : r;
`ifndef CLK_DIV_ODD_EN
    n = n - (n % 2);
`endif
    return n;
  endfunction

  // Output after t counted edges: low for ceil(N/2) edges, then high for floor(N/2).
  task automatic model_step();
    int unsigned n;
    m_act = en && (ratio >= 2);
    if (rst || !m_act) begin
      mt = 0;
      mq = 1'b0;
    end else begin
      mt++;
      n  = neff(ratio);
      mq = ((mt % n) >= ((n + 1) / 2));
    end
  endtask

  task automatic chk_int(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, exp);
    end
  endtask

  task automatic sample(input bit is_pos);
    logic exp;
    exp = m_act ? mq : clk;
    n_assert++;
    assert (o_div_clk === exp) else begin
      n_fail++;
      $error("FAIL out_%s t=%0t ratio=%0d en=%b rst=%b observed=%b expected=%b",
             is_pos ? "pos" : "neg", $time, ratio, en, rst, o_div_clk, exp);
    end
    if (!prev_o && o_div_clk) begin
      prev_rise = last_rise;
      last_rise = $time;
    end
    if (prev_o && !o_div_clk) begin
      hi_len = $time - last_rise;
    end
    prev_o = o_div_clk;
    if (is_pos) last_pos_o = o_div_clk;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1 sample(1'b1);
    @(negedge clk);
    #1 sample(1'b0);
  endtask

  task automatic cycles(input int unsigned k);
    for (int unsigned i = 0; i < k; i++) cycle();
  endtask

  // Bounded wait: returns posedges until the output is first seen high, or 21.
  task automatic edges_to_rise(output int unsigned k);
    k = 21;
    for (int unsigned i = 1; i <= 20; i++) begin
      cycle();
      if (last_pos_o === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  initial begin
    int unsigned k;
    int unsigned n;
    n_assert  = 0;
    n_fail    = 0;
    mt        = 0;
    mq        = 1'b0;
    m_act     = 1'b0;
    prev_o    = 1'b0;
    last_pos_o = 1'b0;
    last_rise = 0;
    prev_rise = 0;
    hi_len    = 0;

    // reset with divide active: output held low
    rst = 1'b1; en = 1'b1; ratio = 5'd4;
    cycles(2);
    chk_int("reset_low", longint'(o_div_clk), 0);

    // ratio 0 then ratio 1: pure bypass
    ratio = 5'd0; rst = 1'b0;
    cycles(4);
    chk_int("ratio0_period", last_rise - prev_rise, 10);
    ratio = 5'd1;
    cycles(4);
    chk_int("ratio1_period", last_rise - prev_rise, 10);

    // ratio 4
    en = 1'b0; cycle();
    ratio = 5'd4; en = 1'b1;
    edges_to_rise(k);
    chk_int("ratio4_first_rise", longint'(k), 2);
    cycles(10);
    chk_int("ratio4_period", last_rise - prev_rise, 40);
    chk_int("ratio4_high", hi_len, 20);

    // ratio 5
    en = 1'b0; cycle();
    ratio = 5'd5; en = 1'b1;
    cycles(16);
    chk_int("ratio5_period", last_rise - prev_rise, longint'(neff(5) * 10));
    chk_int("ratio5_high", hi_len, 20);

    // sweep 2..9, each preceded by reset
    for (int unsigned r = 2; r <= 9; r++) begin
      rst = 1'b1; ratio = 5'(r); cycle();
      rst = 1'b0;
      cycles(3 * r + 2);
      chk_int($sformatf("sweep%0d_period", r), last_rise - prev_rise, longint'(neff(r) * 10));
    end

    // truncation above MAX_RATIO
    rst = 1'b1; ratio = 5'd25; cycle();
    rst = 1'b0;
    cycles(25);
    chk_int("trunc_period", last_rise - prev_rise, 100);

    // disabled with ratio 6: bypass
    en = 1'b0; ratio = 5'd6;
    cycles(4);
    chk_int("en0_period", last_rise - prev_rise, 10);

    // reset mid-high-phase at ratio 8
    rst = 1'b1; en = 1'b1; ratio = 5'd8; cycle();
    rst = 1'b0;
    edges_to_rise(k);
    chk_int("r8_first_rise", longint'(k), 4);
    cycles(2);
    rst = 1'b1;
    cycle();
    chk_int("r8_reset_low", longint'(o_div_clk), 0);
    cycle();
    rst = 1'b0;
    edges_to_rise(k);
    chk_int("r8_rise_after_release", longint'(k), 4);
    cycles(18);
    chk_int("r8_period", last_rise - prev_rise, 80);

    // randomized segments; ratio only changes across a restart
    for (int unsigned s = 0; s < 40; s++) begin
      if ($urandom_range(0, 3) == 0) rst = 1'b1; else en = 1'b0;
      cycle();
      ratio = 5'($urandom_range(0, 31));
      rst   = 1'b0;
      en    = ($urandom_range(0, 4) != 0);
      n = $urandom_range(5, 30);
      for (int unsigned i = 0; i < n; i++) begin
        if ($urandom_range(0, 19) == 0) rst = 1'b1;
        cycle();
        rst = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div.md
CLK_DIV -- requirements
Module: clk_div

Interface
REQ-001 SHALL have parameter MAX_RATIO, default 10: largest division ratio the block supports.
REQ-002 SHALL have parameter RATIO_BIT, default $clog2(MAX_RATIO)+1 (5): width of the ratio input.
REQ-003 SHALL have port i_ref_clk, input, 1 bit: reference clock; the only clock in the block.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, synchronous to i_ref_clk and active-high.
REQ-005 SHALL have port i_clk_en, input, 1 bit: divider enable; 1 = divide, 0 = bypass.
REQ-006 SHALL have port i_div_ratio, input, RATIO_BIT bits: unsigned division ratio N.
REQ-007 SHALL have port o_div_clk, output, 1 bit: divided clock, or i_ref_clk in bypass.

Function
REQ-008 SHALL define divide-active as i_clk_en=1 and N>=2; every other case is bypass.
REQ-009 SHALL in bypass drive o_div_clk = i_ref_clk through a combinational mux (N=0, N=1 or i_clk_en=0).
REQ-010 SHALL when divide-active drive o_div_clk from an internal register div_q, updated only on posedge i_ref_clk.
REQ-011 SHALL use a phase counter cnt of RATIO_BIT bits that increments on each posedge while divide-active.
REQ-012 SHALL toggle div_q and clear cnt on the posedge where cnt >= phase_len-1; the >= comparison means a ratio decrease mid-phase ends that phase on the next edge and never causes counter wrap.
REQ-013 SHALL for even N use phase_len = N/2 for both phases: period N x Tref, 50% duty.
REQ-014 SHALL for odd N use high phase_len = (N-1)/2 and low phase_len = (N+1)/2: period N x Tref.
REQ-015 SHALL make the first edge after enable or reset release a rising edge of div_q, occurring phase_len(low) posedges later.
REQ-016 SHALL clear cnt and div_q on the next posedge when i_clk_en falls or N drops below 2; a later re-enable restarts per REQ-015.
REQ-017 SHALL truncate N > MAX_RATIO to MAX_RATIO.

Reset
REQ-018 SHALL while i_rst=1 clear cnt=0 and div_q=0 at each posedge; the reset has no asynchronous path.
REQ-019 SHALL keep the output mux select independent of i_rst: o_div_clk reads 0 in reset when divide-active, and i_ref_clk otherwise.
REQ-020 SHALL when i_rst asserts mid-operation force div_q low at the next posedge; counting resumes on the first posedge after release.

Configuration
REQ-021 SHALL provide macro CLK_DIV_ODD_EN.
- Defined: odd N behaves per REQ-014.
- Undefined: the LSB of N is ignored for N>=2, so N=3 divides by 2 and N=5 divides by 4. N=0 and N=1 still select bypass.

Structure
REQ-022 SHALL place MAX_RATIO, RATIO_BIT defaults and a ratio_t typedef (logic [RATIO_BIT-1:0]) in package clk_div_pkg.
REQ-023 SHALL place the counter, comparator and phase-length logic in one sub-module clk_div_cnt; the top level holds div_q and the output mux.

Verification
REQ-024 SHALL cover ratio 0, then ratio 1, with Tref=10 ns and en=1: o_div_clk period 10 ns, identical to i_ref_clk.
REQ-025 SHALL cover ratio 4, en=1: o_div_clk period 40 ns, high 20 ns, low 20 ns; first rise 2 posedges after enable.
REQ-026 SHALL cover ratio 5, en=1 with CLK_DIV_ODD_EN defined: period 50 ns, high 20 ns, low 30 ns; with it undefined, period 40 ns.
REQ-027 SHALL cover a sweep of ratios 2..9, each preceded by reset: measured rise-to-rise period = N x 10 ns for every N (even N only without the macro).
REQ-028 SHALL cover en=0 with ratio 6: o_div_clk follows i_ref_clk, 10 ns period.
REQ-029 SHALL cover i_rst=1 for 2 cycles mid-high-phase at ratio 8: o_div_clk low at the next posedge; after release, first rise after 4 posedges, then 80 ns period.
